rca_pipe_param: RTL and testbench



---
 rtl/rca_pipe_param.sv | 124 ++++++++++++
 tb/tb_rca_pipe_param.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_pipe_param.sv
// Pipelined ripple-carry add/subtract: one SEG-bit slice per register stage, valid/ready handshake.
// Optional signed-overflow output Ovf is enabled by defining RCA_PIPE_OVF_EN.
module rca_pipe_param #(
    parameter int WIDTH = 12,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry
`ifdef RCA_PIPE_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int STAGES = (WIDTH / SEG < 1) ? 1 : WIDTH / SEG;
    localparam int LAST   = STAGES - 1;

    logic             vld [STAGES];
    logic             cry [STAGES];
    logic [WIDTH-1:0] acc [STAGES];
    logic [WIDTH-1:0] opa [STAGES];
    logic [WIDTH-1:0] opb [STAGES];

    logic             srcv [STAGES];
    logic             srcc [STAGES];
    logic [WIDTH-1:0] srca [STAGES];
    logic [WIDTH-1:0] srcb [STAGES];
    logic [WIDTH-1:0] srcs [STAGES];
    logic [WIDTH-1:0] nsum [STAGES];
    logic             ncry [STAGES];

    logic [STAGES:0]  rdy;

    // A stage may load when it is empty or its contents move on this cycle.
    always_comb begin
        rdy[STAGES] = out_ready;
        for (int k = LAST; k >= 0; k--) begin
            rdy[k] = !vld[k] || rdy[k+1];
        end
    end

    always_comb begin
        logic [SEG:0] seg;
        seg     = '0;
        srcv[0] = in_valid;
        srca[0] = i1;
        srcb[0] = sub ? ~i2 : i2;
        srcc[0] = sub | Cin;
        srcs[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            srcv[k] = vld[k-1];
            srca[k] = opa[k-1];
            srcb[k] = opb[k-1];
            srcc[k] = cry[k-1];
            srcs[k] = acc[k-1];
        end
        // Each stage ripples only its own slice, using the carry registered by the stage before.
        for (int k = 0; k < STAGES; k++) begin
            seg = {1'b0, srca[k][k*SEG +: SEG]} + {1'b0, srcb[k][k*SEG +: SEG]}
                + {{SEG{1'b0}}, srcc[k]};
            nsum[k]                = srcs[k];
            nsum[k][k*SEG +: SEG]  = seg[SEG-1:0];
            ncry[k]                = seg[SEG];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                vld[k] <= 1'b0;
                cry[k] <= 1'b0;
                acc[k] <= '0;
                opa[k] <= '0;
                opb[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    vld[k] <= srcv[k];
                    if (srcv[k]) begin
                        acc[k] <= nsum[k];
                        cry[k] <= ncry[k];
                        opa[k] <= srca[k];
                        opb[k] <= srcb[k];
                    end
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld[LAST];
    assign Sum       = acc[LAST];
    assign Carry     = cry[LAST];

`ifdef RCA_PIPE_OVF_EN
    // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
    logic ovf_r;
    logic ovf_n;

    assign ovf_n = srca[LAST][WIDTH-1] ^ srcb[LAST][WIDTH-1] ^ nsum[LAST][WIDTH-1] ^ ncry[LAST];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (rdy[LAST] && srcv[LAST]) begin
            ovf_r <= ovf_n;
        end
    end

    assign Ovf = ovf_r;
`endif

endmodule

// File: tb/tb_rca_pipe_param.sv
// Directed self-checking bench for rca_pipe_param (WIDTH=12, SEG=4, three stages).
// Also checks Ovf when RCA_PIPE_OVF_EN is defined.
module tb_rca_pipe_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] i1;
    logic [11:0] i2;
    logic        Cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] Sum;
    logic        Carry;
`ifdef RCA_PIPE_OVF_EN
    logic        Ovf;
`endif

    int tests = 0;
    int fails = 0;

    localparam logic [11:0] STALL_A   [5] = '{12'h100, 12'h200, 12'h300, 12'h400, 12'h500};
    localparam logic [11:0] STALL_B   [5] = '{12'h001, 12'h002, 12'h003, 12'h004, 12'h005};
    localparam logic [11:0] STALL_EXP [5] = '{12'h101, 12'h202, 12'h303, 12'h404, 12'h505};

    always #5 clk = ~clk;

    rca_pipe_param #(.WIDTH(12), .SEG(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .i1        (i1),
        .i2        (i2),
        .Cin       (Cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Carry     (Carry)
`ifdef RCA_PIPE_OVF_EN
        ,
        .Ovf       (Ovf)
`endif
    );

    task automatic send_beat(input logic [11:0] a, input logic [11:0] b, input logic c, input logic s);
        i1       = a;
        i2       = b;
        Cin      = c;
        sub      = s;
        in_valid = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || Sum !== 12'h000 || Carry !== 1'b0)
            $display("[TB] FAIL reset_state: out_valid=%b Sum=%h Carry=%b, required 0/000/0", out_valid, Sum, Carry);
        else ;
        if (out_valid !== 1'b0 || Sum !== 12'h000 || Carry !== 1'b0) fails++;
`ifdef RCA_PIPE_OVF_EN
        tests++;
        if (Ovf !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_ovf: Ovf=%b, required 0", Ovf);
        end
`endif
        rst_n = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_in_ready: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_add_wrap;
        out_ready = 1'b1;
        send_beat(12'hFFF, 12'h001, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("[TB] FAIL wrap_early_valid cycle %0d: out_valid=%b, required 0", c, out_valid);
            end
            @(negedge clk);
        end
        tests++;
        if (out_valid !== 1'b1 || Sum !== 12'h000 || Carry !== 1'b1) begin
            fails++;
            $display("[TB] FAIL wrap_result: out_valid=%b Sum=%h Carry=%b, required 1/000/1", out_valid, Sum, Carry);
        end
`ifdef RCA_PIPE_OVF_EN
        tests++;
        if (Ovf !== 1'b0) begin
            fails++;
            $display("[TB] FAIL wrap_ovf: Ovf=%b, required 0", Ovf);
        end
`endif
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL wrap_drained: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [11:0] a [3];
        logic [11:0] b [3];
        logic        c [3];
        logic [11:0] es [3];
        logic        ec [3];
        a  = '{12'h123, 12'h800, 12'hABC};
        b  = '{12'h456, 12'h800, 12'h000};
        c  = '{1'b0, 1'b0, 1'b1};
        es = '{12'h579, 12'h000, 12'hABD};
        ec = '{1'b0, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            send_beat(a[j], b[j], c[j], 1'b0);
            #1;
            tests++;
            if (in_ready !== 1'b1) begin
                fails++;
                $display("[TB] FAIL b2b_in_ready beat %0d: in_ready=%b, required 1", j, in_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tests++;
            if (out_valid !== 1'b1 || Sum !== es[j] || Carry !== ec[j]) begin
                fails++;
                $display("[TB] FAIL b2b_result %0d: out_valid=%b Sum=%h Carry=%b, required 1/%h/%b",
                         j, out_valid, Sum, Carry, es[j], ec[j]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall;
        int  idx;
        int  k;
        int  c;
        logic pend;
        idx = 0;
        k   = 0;
        out_ready = 1'b0;
        for (int n = 0; n < 6; n++) begin
            if (idx < 5) send_beat(STALL_A[idx], STALL_B[idx], 1'b0, 1'b0);
            else in_valid = 1'b0;
            #1;
            pend = in_valid && in_ready;
            @(negedge clk);
            if (pend) idx++;
            if (out_valid === 1'b1) begin
                tests++;
                if (Sum !== 12'h101 || Carry !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL stall_hold cycle %0d: Sum=%h Carry=%b, required 101/0", n, Sum, Carry);
                end
            end
        end
        tests++;
        if (idx !== 3) begin
            fails++;
            $display("[TB] FAIL stall_accept_count: accepted=%0d, required 3", idx);
        end
        send_beat(STALL_A[3], STALL_B[3], 1'b0, 1'b0);
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL stall_in_ready: in_ready=%b, required 0", in_ready);
        end
        out_ready = 1'b1;
        c = 0;
        while (k < 5 && c < 20) begin
            if (idx < 5) send_beat(STALL_A[idx], STALL_B[idx], 1'b0, 1'b0);
            else in_valid = 1'b0;
            #1;
            pend = in_valid && in_ready;
            if (out_valid === 1'b1) begin
                tests++;
                if (Sum !== STALL_EXP[k] || Carry !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL stall_drain %0d: Sum=%h Carry=%b, required %h/0", k, Sum, Carry, STALL_EXP[k]);
                end
                k++;
            end
            @(negedge clk);
            if (pend) idx++;
            c++;
        end
        in_valid = 1'b0;
        tests++;
        if (k !== 5 || idx !== 5) begin
            fails++;
            $display("[TB] FAIL stall_complete: results=%0d accepted=%0d, required 5/5", k, idx);
        end
    endtask

    task automatic test_sub;
        out_ready = 1'b1;
        send_beat(12'h005, 12'h007, 1'b1, 1'b1);
        @(negedge clk);
        send_beat(12'h007, 12'h005, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || Sum !== 12'hFFE || Carry !== 1'b0) begin
            fails++;
            $display("[TB] FAIL sub_borrow: out_valid=%b Sum=%h Carry=%b, required 1/FFE/0", out_valid, Sum, Carry);
        end
`ifdef RCA_PIPE_OVF_EN
        tests++;
        if (Ovf !== 1'b0) begin
            fails++;
            $display("[TB] FAIL sub_borrow_ovf: Ovf=%b, required 0", Ovf);
        end
`endif
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || Sum !== 12'h002 || Carry !== 1'b1) begin
            fails++;
            $display("[TB] FAIL sub_noborrow: out_valid=%b Sum=%h Carry=%b, required 1/002/1", out_valid, Sum, Carry);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midflight;
        out_ready = 1'b1;
        send_beat(12'h111, 12'h111, 1'b0, 1'b0);
        @(negedge clk);
        send_beat(12'h333, 12'h111, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || Sum !== 12'h000 || Carry !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midflight_reset: out_valid=%b Sum=%h Carry=%b, required 0/000/0", out_valid, Sum, Carry);
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL midflight_in_ready: in_ready=%b, required 1", in_ready);
        end
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("[TB] FAIL midflight_stale cycle %0d: out_valid=%b Sum=%h, required 0", n, out_valid, Sum);
            end
        end
        send_beat(12'h0F0, 12'h00F, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        for (int n = 0; n < 2; n++) begin
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("[TB] FAIL midflight_early cycle %0d: out_valid=%b, required 0", n, out_valid);
            end
            @(negedge clk);
        end
        tests++;
        if (out_valid !== 1'b1 || Sum !== 12'h0FF || Carry !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midflight_new: out_valid=%b Sum=%h Carry=%b, required 1/0FF/0", out_valid, Sum, Carry);
        end
        @(negedge clk);
    endtask

`ifdef RCA_PIPE_OVF_EN
    task automatic test_ovf;
        out_ready = 1'b1;
        send_beat(12'h7FF, 12'h001, 1'b0, 1'b0);
        @(negedge clk);
        send_beat(12'h800, 12'h001, 1'b0, 1'b1);
        @(negedge clk);
        send_beat(12'h123, 12'h001, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || Sum !== 12'h800 || Carry !== 1'b0 || Ovf !== 1'b1) begin
            fails++;
            $display("[TB] FAIL ovf_add: v=%b Sum=%h Carry=%b Ovf=%b, required 1/800/0/1", out_valid, Sum, Carry, Ovf);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || Sum !== 12'h7FF || Carry !== 1'b1 || Ovf !== 1'b1) begin
            fails++;
            $display("[TB] FAIL ovf_sub: v=%b Sum=%h Carry=%b Ovf=%b, required 1/7FF/1/1", out_valid, Sum, Carry, Ovf);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || Sum !== 12'h124 || Carry !== 1'b0 || Ovf !== 1'b0) begin
            fails++;
            $display("[TB] FAIL ovf_none: v=%b Sum=%h Carry=%b Ovf=%b, required 1/124/0/0", out_valid, Sum, Carry, Ovf);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        i1        = '0;
        i2        = '0;
        Cin       = 1'b0;
        sub       = 1'b0;
        test_reset();
        test_add_wrap();
        test_back_to_back();
        test_stall();
        test_sub();
        test_reset_midflight();
`ifdef RCA_PIPE_OVF_EN
        test_ovf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
